mult_share_arbiter: RTL and testbench

Shares one unsigned WIDTH×WIDTH multiplier between NREQ requesters. The block grants requesters in round-robin order and registers the granted operands. It computes the full-width product in a dedicated cycle, then holds the tagged result on a valid/ready response port until the consumer accepts it. It sits between the arithmetic-circuit clients and the combinational multiplier datapath and serialises all access to it.

---
 rtl/mult_share_arbiter_if.sv | 62 ++++++
 rtl/mult_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter_if
//
// Bundles the request and response handshakes of the shared multiplier.
//
// Handshake rules (valid/ready on both sides):
//   A transfer happens only on a rising clock edge where valid and ready are
//   both high. A source that raises valid keeps its payload stable until that
//   edge, or drops valid (a request withdrawn before grant is skipped).
//   The arbiter's ready may depend combinationally on valid. The response
//   valid never depends on rsp_ready.
//
// Signals:
//   req_valid [NREQ]        per-requester request valid       (master -> slave)
//   req_a     [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b     [NREQ*WIDTH]  operand B, same packing
//   req_ready [NREQ]        one-hot grant                      (slave -> master)
//   rsp_valid               result valid                       (slave -> master)
//   rsp_id    [IDW]         requester that owns the result
//   rsp_out   [2*WIDTH]     unsigned product
//   rsp_ready               consumer accepts the result        (master -> slave)
//
// Modports:
//   master - requesters plus result consumer
//   slave  - the arbiter
// -----------------------------------------------------------------------------
interface mult_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_out;
    logic                  rsp_ready;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_out,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_out,
        input  rsp_ready
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Serialises access to one unsigned WIDTH x WIDTH multiplier among NREQ
// requesters. A round-robin arbiter grants one requester in IDLE and its
// operands are captured. The full 2*WIDTH-bit product is registered in MUL.
// The tagged result is then held on the response port in RESP until the
// consumer accepts it.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   bus        slave modport of mult_share_arbiter_if (request/response)
//   done_count out  16-bit completed-transaction counter, wraps to 0
//   fsm_state  out  current FSM state (0 IDLE, 1 MUL, 2 RESP), for observation
//
// Timing: grant in cycle T, MUL in T+1, rsp_valid from T+2 until accepted.
// After acceptance the FSM returns to IDLE, so at most one product is issued
// every three cycles.
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus,
    output logic [15:0]         done_count,
    output logic [1:0]          fsm_state
);

    localparam int PW = 2 * WIDTH;
    // NREQ at the width of the rotated scan index, used for the modulo wrap.
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [IDW-1:0]   id_q;
    logic [PW-1:0]    rsp_out_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_valid_q;
    logic [15:0]      done_count_q;

    // Arbitration results
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand_sum;
    logic [IDW-1:0]   cand_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [NREQ-1:0]  req_ready_c;
    logic [IDW-1:0]   ptr_next;

    // Round-robin scan: ptr, ptr+1, ... mod NREQ. The first valid requester
    // wins. ptr always points one past the last served requester, so the
    // last served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
            // ptr + k < 2*NREQ, so a single subtraction is a full modulo.
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            cand_idx = cand_sum[IDW-1:0];
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_c = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    // Pointer advances past the requester whose result was just accepted.
    assign ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            rsp_out_q    <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        op_a_q  <= sel_a;
                        op_b_q  <= sel_b;
                        id_q    <= grant_idx;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    // Both operands widened first so the product is never truncated.
                    rsp_out_q   <= PW'(op_a_q) * PW'(op_b_q);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // The result registers are not written here, so they
                    // stay frozen while the consumer stalls.
                    if (bus.rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        ptr_q        <= ptr_next;
                        done_count_q <= done_count_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign done_count    = done_count_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Self-checking bench for mult_share_arbiter. Expected {id, product} pairs
// go into exp_q when a grant is observed. They are popped and compared when
// the response appears. Inputs are driven 1 time unit after the rising edge
// and outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int PW    = 2 * WIDTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] done_count;
    logic [1:0]  fsm_state;

    mult_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .done_count (done_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [IDW+PW-1:0] exp_q[$];
    logic [15:0]       exp_done;
    int                n_checks = 0;
    int                n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input int a, input int b);
        bus.req_valid[id]              = 1'b1;
        bus.req_a[id*WIDTH +: WIDTH]   = WIDTH'(a);
        bus.req_b[id*WIDTH +: WIDTH]   = WIDTH'(b);
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_done = 16'd0;
    endtask

    // One request from an idle arbiter with no other requester valid.
    // stall = number of response cycles held with rsp_ready low.
    task automatic run_single(input int id, input int a, input int b,
                              input int stall, input string tag);
        logic [IDW+PW-1:0] exp;
        logic [NREQ-1:0]   onehot;
        int                other;
        onehot = NREQ'(1) << id;
        other  = (id + 1) % NREQ;
        tick();
        bus.req_valid = '0;
        drive_req(id, a, b);
        bus.rsp_ready = (stall == 0);
        #1;
        n_checks++;
        if (bus.req_ready !== onehot) begin
            n_fail++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, bus.req_ready, onehot);
        end
        exp_q.push_back({IDW'(id), PW'(a * b)});

        tick();                       // MUL cycle
        bus.req_valid = '0;
        #1;
        n_checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s mul_cycle: req_ready=%b rsp_valid=%b expected 0/0",
                     tag, bus.req_ready, bus.rsp_valid);
        end

        tick();                       // T+2: response must be up
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rsp_valid_latency: rsp_valid=%b expected 1", tag, bus.rsp_valid);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({bus.rsp_id, bus.rsp_out} !== exp) begin
            n_fail++;
            $display("FAIL %s result: id=%0d out=%0d expected id=%0d out=%0d",
                     tag, bus.rsp_id, bus.rsp_out, exp[IDW+PW-1:PW], exp[PW-1:0]);
        end

        for (int s = 0; s < stall; s++) begin
            bus.req_valid[other] = 1'b1;
            #1;
            n_checks++;
            if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b1 ||
                {bus.rsp_id, bus.rsp_out} !== exp || done_count !== exp_done) begin
                n_fail++;
                $display("FAIL %s stall%0d: req_ready=%b rsp_valid=%b id=%0d out=%0d cnt=%0d expected 0/1/%0d/%0d/%0d",
                         tag, s, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_out,
                         done_count, exp[IDW+PW-1:PW], exp[PW-1:0], exp_done);
            end
            tick();
        end

        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();                       // acceptance edge
        exp_done = exp_done + 16'd1;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || done_count !== exp_done) begin
            n_fail++;
            $display("FAIL %s accept: rsp_valid=%b done_count=%0d expected 0/%0d",
                     tag, bus.rsp_valid, done_count, exp_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 ||
            bus.rsp_out !== '0 || done_count !== 16'd0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: rr=%b rv=%b id=%0d out=%0d cnt=%0d st=%0d expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_out, done_count, fsm_state);
        end
    endtask

    task automatic test_single();
        run_single(0, 11, 12, 0, "single");
    endtask

    task automatic test_extremes();
        run_single(1, 15, 15, 0, "ext_15x15");
        run_single(2, 0, 9, 0, "ext_0x9");
        run_single(3, 2, 2, 0, "ext_2x2");
    endtask

    task automatic test_backpressure();
        run_single(2, 7, 9, 5, "backpressure");
    endtask

    task automatic test_round_robin();
        int                grants;
        int                resps;
        int                last_grant;
        logic [IDW+PW-1:0] exp;
        logic [NREQ-1:0]   onehot;
        grants     = 0;
        resps      = 0;
        last_grant = -1;
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) drive_req(i, i + 1, 3);
        for (int cyc = 0; cyc < 60 && (grants < 5 || resps < 5); cyc++) begin
            if (cyc > 0) tick();
            if (grants >= 5) bus.req_valid = '0;
            #1;
            if (bus.req_ready !== '0) begin
                onehot = NREQ'(1) << (grants % NREQ);
                n_checks++;
                if (bus.req_ready !== onehot) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: req_ready=%b expected %b", grants, bus.req_ready, onehot);
                end
                if (last_grant >= 0) begin
                    n_checks++;
                    if (cyc - last_grant != 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing%0d: spacing=%0d expected 3", grants, cyc - last_grant);
                    end
                end
                exp_q.push_back({IDW'(grants % NREQ), PW'(((grants % NREQ) + 1) * 3)});
                last_grant = cyc;
                grants++;
            end
            if (bus.rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_unexpected: id=%0d out=%0d expected no response", bus.rsp_id, bus.rsp_out);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_out} !== exp) begin
                        n_fail++;
                        $display("FAIL rr_result%0d: id=%0d out=%0d expected id=%0d out=%0d",
                                 resps, bus.rsp_id, bus.rsp_out, exp[IDW+PW-1:PW], exp[PW-1:0]);
                    end
                end
                resps++;
            end
        end
        n_checks++;
        if (grants != 5 || resps != 5) begin
            n_fail++;
            $display("FAIL rr_timeout: grants=%0d responses=%0d expected 5/5", grants, resps);
        end
        tick();
        n_checks++;
        if (done_count !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_count: done_count=%0d expected 5", done_count);
        end
        exp_done = 16'd5;
    endtask

    task automatic test_reset_mid_op();
        logic [IDW+PW-1:0] exp;
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drive_req(1, 5, 6);
        tick();                       // grant edge -> MUL
        bus.req_valid = '0;
        rst_n = 1'b0;
        drive_req(2, 4, 7);
        drive_req(3, 9, 9);
        #1;
        n_checks++;
        if (fsm_state !== 2'd1 || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL midrst_pre: state=%0d req_ready=%b expected 1/0", fsm_state, bus.req_ready);
        end
        tick();                       // reset edge while in MUL
        #1;
        n_checks++;
        if (fsm_state !== 2'd0 || bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_id !== '0 || bus.rsp_out !== '0 || done_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: st=%0d rr=%b rv=%b id=%0d out=%0d cnt=%0d expected all 0",
                     fsm_state, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_out, done_count);
        end
        exp_q.delete();
        exp_done = 16'd0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL midrst_grant: req_ready=%b expected 0100", bus.req_ready);
        end
        exp_q.push_back({IDW'(2), PW'(28)});
        tick();                       // MUL
        bus.req_valid = '0;
        tick();                       // RESP
        #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_out} !== exp) begin
            n_fail++;
            $display("FAIL midrst_result: rv=%b id=%0d out=%0d expected 1/%0d/%0d",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_out, exp[IDW+PW-1:PW], exp[PW-1:0]);
        end
        tick();                       // acceptance
        exp_done = exp_done + 16'd1;
        #1;
        n_checks++;
        if (done_count !== exp_done || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_count: done_count=%0d rv=%b expected %0d/0",
                     done_count, bus.rsp_valid, exp_done);
        end
    endtask

    task automatic test_wrap();
        tick();
        force dut.done_count_q = 16'hFFFF;
        #1;
        release dut.done_count_q;
        exp_done = 16'hFFFF;
        run_single(1, 3, 5, 0, "wrap");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        exp_done      = 16'd0;
        test_reset();
        test_single();
        test_extremes();
        test_backpressure();
        test_round_robin();
        test_reset_mid_op();
        test_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
